inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//  Fetch-to-decode instruction queue: circular buffer of fetch packets (ID_WIDTH insts each).
//  Frontend pushes packets on the enqueue side; decode/rename pops through the fifo_backend_itf
//  fields: valid, ready, packet.{pc, inst, valid, predict_taken, predict_target}.
//  Decouples fetch stalls from rename backpressure. Discards all contents on a backend redirect.
// PARAMETERS
//  ID_WIDTH  2  instructions per packet; equals decode width
//  DEPTH     8  packet entries; power of 2, >= 2
// PORTS
//  clk                 in   1              clock
//  rst                 in   1              asynchronous, active-high reset
//  flush               in   1              backend redirect; empty the queue
//  in_valid            in   1              fetch presents a packet
//  in_ready            out  1              queue can accept a packet
//  in_pc               in   32             PC of slot 0; slot i is at in_pc + 4*i
//  in_inst             in   ID_WIDTH*32    instruction words
//  in_slot_valid       in   ID_WIDTH       per-slot valid mask
//  in_predict_taken    in   ID_WIDTH       per-slot branch prediction
//  in_predict_target   in   ID_WIDTH*32    per-slot predicted next PC
//  out_valid           out  1              head packet available (from_fifo.valid)
//  out_ready           in   1              decode consumes head (from_fifo.ready)
//  out_pc / out_inst / out_slot_valid /
//  out_predict_taken / out_predict_target  out  (widths as in_*)  head packet fields
//  count               out  $clog2(DEPTH)+1  occupied entries (perf/debug)
// BEHAVIOUR
//  Reset, asynchronous, while rst=1:
//   - head=0, tail=0, count=0, out_valid=0, in_ready=1.
//   - Storage array is not reset. out_* data are don't-care while out_valid=0.
//  Push: in_valid && in_ready at a clk edge.
//   - Writes mem[tail]; tail <= tail+1 mod DEPTH.
//   - If in_slot_valid == 0, the packet is accepted (handshake completes) but not stored.
//  Pop: out_valid && out_ready at a clk edge. head <= head+1 mod DEPTH.
//  Outputs:
//   - in_ready = (count != DEPTH). No pop-through: a full queue stalls fetch even when a pop
//     occurs in the same cycle.
//   - out_valid = (count != 0). out_* = mem[head], show-ahead, combinational from registers.
//   - No bypass: a packet pushed at edge N is visible on out_* after edge N (1-cycle latency).
//  count:
//   - +1 on push-only, -1 on pop-only, unchanged on simultaneous push+pop.
//   - Push+pop while count=1 is legal: the old head leaves, the new packet becomes head.
//   - Never exceeds DEPTH and never underflows. Pointers are $clog2(DEPTH) bits and wrap
//     naturally.
//  Stability: while out_valid && !out_ready, out_* hold stable. Decode can hold the head
//   across multiple cycles (partial dispatch).
//  Flush: synchronous, highest priority.
//   - At the edge where flush=1, head, tail and count go to 0.
//   - Any push or pop in that cycle is ignored. A pop handshake may still be observed by decode;
//     decode discards it on redirect.
//   - Cycle after flush: out_valid=0, in_ready=1.
//  Asserting rst mid-operation drops all packets immediately. No entry survives reset.
//  Assertions: count <= DEPTH; out_* stable while out_valid && !out_ready; no push when
//   count==DEPTH.
// TESTING
//  1. Reset, push pc=0x1eceb000 inst={0x00100093,0x00200113} mask=11 -> next cycle out_valid=1,
//     out_pc=0x1eceb000, count=1.
//  2. Hold out_ready=0, push 8 packets -> in_ready=0 at count=8. A 9th push is refused and fetch
//     holds its data. Then out_ready=1 -> packets pop in order and the pointers wrap.
//  3. count=1 with simultaneous push+pop -> count stays 1 and out_pc becomes the new packet's pc.
//     At count=8, push+pop -> the push is not accepted and count=7.
//  4. count=5 with flush=1, in_valid=1, out_ready=1 in the same cycle -> next cycle count=0,
//     out_valid=0, in_ready=1. The packet presented with the flush is not stored.
//  5. Push with in_slot_valid=00 -> in_ready=1, count unchanged, out_valid stays 0.
//  6. Assert rst mid-stream at count=4 -> out_valid=0 and count=0 without waiting for a clk edge.
//     After release, the first push is returned first.

Source files
------------

// File: rtl/inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// Enqueue side (fetch -> queue):
//   in_valid, in_ready, in_pc, in_inst, in_slot_valid, in_predict_taken, in_predict_target
// Dequeue side (queue -> decode):
//   out_valid, out_ready, out_pc, out_inst, out_slot_valid, out_predict_taken, out_predict_target
// Modports:
//   slave  - the queue itself (accepts packets, presents the head packet)
//   master - the surrounding fetch/decode environment
interface inst_queue_if #(
  parameter int ID_WIDTH = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [ID_WIDTH*32-1:0]   in_inst;
  logic [ID_WIDTH-1:0]      in_slot_valid;
  logic [ID_WIDTH-1:0]      in_predict_taken;
  logic [ID_WIDTH*32-1:0]   in_predict_target;

  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [ID_WIDTH*32-1:0]   out_inst;
  logic [ID_WIDTH-1:0]      out_slot_valid;
  logic [ID_WIDTH-1:0]      out_predict_taken;
  logic [ID_WIDTH*32-1:0]   out_predict_target;

  modport slave (
    input  in_valid, in_pc, in_inst, in_slot_valid, in_predict_taken, in_predict_target,
    output in_ready,
    output out_valid, out_pc, out_inst, out_slot_valid, out_predict_taken, out_predict_target,
    input  out_ready
  );

  modport master (
    output in_valid, in_pc, in_inst, in_slot_valid, in_predict_taken, in_predict_target,
    input  in_ready,
    input  out_valid, out_pc, out_inst, out_slot_valid, out_predict_taken, out_predict_target,
    output out_ready
  );
endinterface

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: a circular buffer of fetch packets that
// decouples fetch stalls from rename backpressure. The head packet is shown
// combinationally from registers; there is no bypass and no pop-through.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset; drops every packet immediately
//   flush  - backend redirect; empties the queue at the next clock edge
//   q_if   - inst_queue_if.slave handshake bundle (enqueue and dequeue sides)
//   count  - number of occupied entries
module inst_queue #(
  parameter int ID_WIDTH = 2,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  inst_queue_if.slave              q_if,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Packet storage; deliberately not reset, validity comes from the count.
  logic [31:0]              pcMem_q     [DEPTH];
  logic [ID_WIDTH*32-1:0]   instMem_q   [DEPTH];
  logic [ID_WIDTH-1:0]      maskMem_q   [DEPTH];
  logic [ID_WIDTH-1:0]      takenMem_q  [DEPTH];
  logic [ID_WIDTH*32-1:0]   targetMem_q [DEPTH];

  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0] count_q,   count_d;

  logic push;
  logic store;
  logic pop;

  // Handshake decode. A packet with an all-zero slot mask completes its
  // handshake but carries nothing, so it never occupies an entry.
  assign q_if.in_ready  = (count_q != CNT_W'(DEPTH));
  assign q_if.out_valid = (count_q != '0);
  assign push  = q_if.in_valid && q_if.in_ready;
  assign store = push && (|q_if.in_slot_valid);
  assign pop   = q_if.out_valid && q_if.out_ready;

  // Show-ahead head packet straight out of storage.
  assign q_if.out_pc             = pcMem_q[headPtr_q];
  assign q_if.out_inst           = instMem_q[headPtr_q];
  assign q_if.out_slot_valid     = maskMem_q[headPtr_q];
  assign q_if.out_predict_taken  = takenMem_q[headPtr_q];
  assign q_if.out_predict_target = targetMem_q[headPtr_q];
  assign count = count_q;

  // Next-state pointers and occupancy; a redirect overrides any handshake
  // in the same cycle. Pointers are power-of-two wide so they wrap freely.
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    if (flush) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end else begin
      if (store) tailPtr_d = tailPtr_q + PTR_W'(1);
      if (pop)   headPtr_d = headPtr_q + PTR_W'(1);
      if (store && !pop)      count_d = count_q + CNT_W'(1);
      else if (!store && pop) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state: cleared asynchronously so no entry survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Storage write; a flushed cycle's packet is dropped with the rest.
  always_ff @(posedge clk) begin
    if (store && !flush) begin
      pcMem_q[tailPtr_q]     <= q_if.in_pc;
      instMem_q[tailPtr_q]   <= q_if.in_inst;
      maskMem_q[tailPtr_q]   <= q_if.in_slot_valid;
      takenMem_q[tailPtr_q]  <= q_if.in_predict_taken;
      targetMem_q[tailPtr_q] <= q_if.in_predict_target;
    end
  end

  // Occupancy bound and full-queue protection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert (!(push && count_q == CNT_W'(DEPTH)));
    end
  end

  // A held head must not change underneath a stalled decode.
  assert property (@(posedge clk) disable iff (rst)
    (q_if.out_valid && !q_if.out_ready && !flush) |=>
      ($stable(q_if.out_pc) && $stable(q_if.out_inst) && $stable(q_if.out_slot_valid) &&
       $stable(q_if.out_predict_taken) && $stable(q_if.out_predict_target)));

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: reset, basic push/pop,
// fill and wrap, simultaneous push+pop, flush, empty-mask packets and
// asynchronous reset mid-stream.
module tb_inst_queue;

  localparam int ID_WIDTH = 2;
  localparam int DEPTH    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] count;
  int         checks   = 0;
  int         failures = 0;

  inst_queue_if #(.ID_WIDTH(ID_WIDTH)) qIf ();

  inst_queue #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q_if  (qIf.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs at a falling edge and returns at the next
  // falling edge, so outputs are sampled well away from the rising edge.
  task automatic applyStimulus(input logic inValid, input logic [31:0] pc,
                               input logic [63:0] inst, input logic [1:0] mask,
                               input logic outReady, input logic flushIn);
    qIf.in_valid          = inValid;
    qIf.in_pc             = pc;
    qIf.in_inst           = inst;
    qIf.in_slot_valid     = mask;
    qIf.in_predict_taken  = mask;
    qIf.in_predict_target = {pc + 32'h104, pc + 32'h100};
    qIf.out_ready         = outReady;
    flush                 = flushIn;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    qIf.in_valid = 1'b0;
    qIf.in_pc = '0;
    qIf.in_inst = '0;
    qIf.in_slot_valid = '0;
    qIf.in_predict_taken = '0;
    qIf.in_predict_target = '0;
    qIf.out_ready = 1'b0;

    // Reset state
    #2;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_out_valid", 64'(qIf.out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(qIf.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // First packet, one-cycle latency to the head
    applyStimulus(1'b1, 32'h1eceb000, {32'h00200113, 32'h00100093}, 2'b11, 1'b0, 1'b0);
    checkOutput("t1_out_valid", 64'(qIf.out_valid), 64'd1);
    checkOutput("t1_out_pc", 64'(qIf.out_pc), 64'h1eceb000);
    checkOutput("t1_count", 64'(count), 64'd1);
    checkOutput("t1_out_inst", qIf.out_inst, 64'h0020011300100093);
    checkOutput("t1_out_target", qIf.out_predict_target, {32'h1eceb104, 32'h1eceb100});
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
    checkOutput("t1_pop_count", 64'(count), 64'd0);
    checkOutput("t1_pop_out_valid", 64'(qIf.out_valid), 64'd0);

    // Empty-mask packet: accepted, not stored
    checkOutput("t5_in_ready", 64'(qIf.in_ready), 64'd1);
    applyStimulus(1'b1, 32'h0000beef, 64'h1, 2'b00, 1'b0, 1'b0);
    checkOutput("t5_count", 64'(count), 64'd0);
    checkOutput("t5_out_valid", 64'(qIf.out_valid), 64'd0);

    // Fill with decode stalled; pointers start at 1 so they wrap
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, 32'h1000 + 32'(k) * 32'h10, {32'(k) + 32'h4, 32'(k)}, 2'b01, 1'b0, 1'b0);
    checkOutput("t2_full_count", 64'(count), 64'd8);
    checkOutput("t2_full_in_ready", 64'(qIf.in_ready), 64'd0);
    checkOutput("t2_full_head", 64'(qIf.out_pc), 64'h1000);
    applyStimulus(1'b1, 32'h2000, 64'h2, 2'b11, 1'b0, 1'b0);
    checkOutput("t2_refused_count", 64'(count), 64'd8);
    checkOutput("t2_refused_head", 64'(qIf.out_pc), 64'h1000);

    // Push+pop at full: the push is refused, only the pop happens
    applyStimulus(1'b1, 32'h2000, 64'h2, 2'b11, 1'b1, 1'b0);
    checkOutput("t3_full_pp_count", 64'(count), 64'd7);
    for (int k = 1; k < 8; k++) begin
      checkOutput($sformatf("t2_order_%0d", k), 64'(qIf.out_pc), 64'h1000 + 64'(k) * 64'h10);
      applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
    end
    checkOutput("t2_drained_count", 64'(count), 64'd0);
    checkOutput("t2_drained_valid", 64'(qIf.out_valid), 64'd0);

    // Push+pop at count=1: new packet becomes the head
    applyStimulus(1'b1, 32'h0000a000, 64'ha, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000b000, 64'hb, 2'b10, 1'b1, 1'b0);
    checkOutput("t3_pp_count", 64'(count), 64'd1);
    checkOutput("t3_pp_head", 64'(qIf.out_pc), 64'hb000);
    checkOutput("t3_pp_mask", 64'(qIf.out_slot_valid), 64'd2);
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);

    // Flush at count=5 with a push and pop presented
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, 32'h3000 + 32'(k) * 32'h10, 64'(k), 2'b11, 1'b0, 1'b0);
    checkOutput("t4_pre_count", 64'(count), 64'd5);
    applyStimulus(1'b1, 32'hdead0000, 64'hd, 2'b11, 1'b1, 1'b1);
    checkOutput("t4_flush_count", 64'(count), 64'd0);
    checkOutput("t4_flush_valid", 64'(qIf.out_valid), 64'd0);
    checkOutput("t4_flush_in_ready", 64'(qIf.in_ready), 64'd1);
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    checkOutput("t4_after_count", 64'(count), 64'd0);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 32'h4000 + 32'(k) * 32'h10, 64'(k), 2'b11, 1'b0, 1'b0);
    checkOutput("t6_pre_count", 64'(count), 64'd4);
    qIf.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_async_valid", 64'(qIf.out_valid), 64'd0);
    checkOutput("t6_async_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h5000, 64'h5, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5010, 64'h6, 2'b11, 1'b0, 1'b0);
    checkOutput("t6_post_head", 64'(qIf.out_pc), 64'h5000);
    checkOutput("t6_post_count", 64'(count), 64'd2);
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
    checkOutput("t6_post_second", 64'(qIf.out_pc), 64'h5010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
